// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational yAlu between two requesters.
// Each requester hands over operands through a valid/ready handshake and gets
// its result back on its own response channel. rsp_z/rsp_zero/rsp_err are
// shared by both channels.
// Optional feature macro: ALU_ARB_RR_EN.
//   defined   -> round-robin arbitration with a last-grant pointer
//   undefined -> fixed priority, requester 0 always wins contention
module alu_arbiter #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    input  logic [2:0]       req0_op,
    input  logic [2:0]       req1_op,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [W-1:0]     rsp_z,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [2:0]       alu_op,
    input  logic [W-1:0]     alu_z,
    input  logic             alu_ex,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic             grant_s;      // 0: requester 0 wins, 1: requester 1 wins
    logic             accept_s;
    logic             done_s;
    logic [W-1:0]     sel_a_s;
    logic [W-1:0]     sel_b_s;
    logic [2:0]       sel_op_s;
    logic             id_q;
    logic             illegal_q;
    logic [W-1:0]     alu_a_q;
    logic [W-1:0]     alu_b_q;
    logic [2:0]       alu_op_q;
    logic [W-1:0]     rsp_z_q;
    logic             rsp_zero_q;
    logic             rsp_err_q;
    logic [CNT_W-1:0] ops_done_q;

    // Opcodes the ALU implements; anything else is answered with rsp_err.
    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            3'b000, 3'b001, 3'b010, 3'b110, 3'b111: op_legal = 1'b1;
            default:                                op_legal = 1'b0;
        endcase
    endfunction

`ifdef ALU_ARB_RR_EN
    logic last_q;   // requester granted most recently

    // Winner selection: alternate under contention, lone requester always wins.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_q;
        end else begin
            grant_s = req1_valid;
        end
    end

    // Last-grant pointer; reset value lets requester 0 win the first contest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (accept_s) begin
            last_q <= grant_s;
        end
    end
`else
    // Winner selection: requester 0 has fixed priority.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid) begin
            grant_s = 1'b0;
        end else begin
            grant_s = req1_valid;
        end
    end
`endif

    // Operand/op mux from the winning requester.
    always_comb begin
        sel_a_s  = req0_a;
        sel_b_s  = req0_b;
        sel_op_s = req0_op;
        if (grant_s) begin
            sel_a_s  = req1_a;
            sel_b_s  = req1_b;
            sel_op_s = req1_op;
        end else begin
            sel_a_s  = req0_a;
            sel_b_s  = req0_b;
            sel_op_s = req0_op;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state, request acceptance and response completion.
    always_comb begin
        state_d    = state_q;
        accept_s   = 1'b0;
        done_s     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept_s   = 1'b1;
                    req0_ready = ~grant_s;
                    req1_ready = grant_s;
                    state_d    = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if ((!id_q && rsp0_ready) || (id_q && rsp1_ready)) begin
                    done_s  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Latch the accepted request; illegal ops never reach the ALU inputs so
    // they keep their previous (legal) values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q      <= 1'b0;
            illegal_q <= 1'b0;
            alu_a_q   <= {W{1'b0}};
            alu_b_q   <= {W{1'b0}};
            alu_op_q  <= 3'b000;
        end else if (accept_s) begin
            id_q <= grant_s;
            if (op_legal(sel_op_s)) begin
                illegal_q <= 1'b0;
                alu_a_q   <= sel_a_s;
                alu_b_q   <= sel_b_s;
                alu_op_q  <= sel_op_s;
            end else begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Capture the ALU result (or the error response) at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_z_q    <= {W{1'b0}};
            rsp_zero_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            if (illegal_q) begin
                rsp_z_q    <= {W{1'b0}};
                rsp_zero_q <= 1'b0;
                rsp_err_q  <= 1'b1;
            end else begin
                rsp_z_q    <= alu_z;
                rsp_zero_q <= alu_ex;
                rsp_err_q  <= 1'b0;
            end
        end
    end

    // Completed-operation counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_done_q <= {CNT_W{1'b0}};
        end else if (done_s) begin
            ops_done_q <= ops_done_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign rsp0_valid = (state_q == ST_RESP) && !id_q;
    assign rsp1_valid = (state_q == ST_RESP) && id_q;
    assign rsp_z      = rsp_z_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: transaction-level reference model plus a
// scoreboard of expected responses per requester, popped by a monitor.
// Honours ALU_ARB_RR_EN for the expected arbitration order.
module tb_alu_arbiter;
    localparam int W     = 32;
    localparam int CNT_W = 4;

    typedef logic [W+1:0] rsp_t;   // {z, zero, err}

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0]     req0_a, req0_b, req1_a, req1_b;
    logic [2:0]       req0_op, req1_op;
    logic             rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [W-1:0]     rsp_z;
    logic             rsp_zero, rsp_err;
    logic [W-1:0]     alu_a, alu_b, alu_z;
    logic [2:0]       alu_op;
    logic             alu_ex;
    logic [CNT_W-1:0] ops_done;

    always #5 clk = ~clk;

    alu_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp_z(rsp_z), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_z(alu_z), .alu_ex(alu_ex), .ops_done(ops_done)
    );

    // Stand-in for yAlu; unknown ops produce garbage so misuse is visible.
    always_comb begin
        case (alu_op)
            3'b000:  alu_z = alu_a & alu_b;
            3'b001:  alu_z = alu_a | alu_b;
            3'b010:  alu_z = alu_a + alu_b;
            3'b110:  alu_z = alu_a - alu_b;
            3'b111:  alu_z = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_z = 32'hDEAD_BEEF;
        endcase
        alu_ex = (alu_z == 32'd0);
    end

    int   total = 0;
    int   bad   = 0;
    // transaction-level model state
    bit   busy = 1'b0;
    int   age = 0;
    bit   owner = 1'b0;
    bit   last_g = 1'b1;
    int   ops_cnt = 0;
    int   acc_id = -1;
    rsp_t exp0[$];
    rsp_t exp1[$];
    int   grants[$];
    logic [W-1:0] last_z;
    logic last_zero, last_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Expected response from the opcode definitions, using wide integer math.
    function automatic rsp_t ref_rsp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0]  s;
        int           sa, sb;
        logic [W-1:0] z;
        logic         err;
        err = 1'b0;
        z   = '0;
        s   = 64'd0;
        sa  = signed'(a);
        sb  = signed'(b);
        case (op)
            3'b000: z = a & b;
            3'b001: z = a | b;
            3'b010: begin s = 64'(a) + 64'(b); z = s[W-1:0]; end
            3'b110: begin s = 64'(a) + (64'h1_0000_0000 - 64'(b)); z = s[W-1:0]; end
            3'b111: z = (sa < sb) ? 32'd1 : 32'd0;
            default: err = 1'b1;
        endcase
        return {z, (z == 32'd0) && !err, err};
    endfunction

    function automatic logic [2:0] rand_op(input bit illegal_ok);
        logic [2:0] ops [5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
        if (illegal_ok) return 3'($urandom_range(0, 7));
        else return ops[$urandom_range(0, 4)];
    endfunction

    function automatic logic [W-1:0] rand_val();
        case ($urandom_range(0, 3))
            0:       return W'($urandom_range(0, 3));
            1:       return 32'hFFFF_FFFF - W'($urandom_range(0, 3));
            default: return W'($urandom);
        endcase
    endfunction

    // One clock cycle; called at a falling edge with inputs already driven.
    task automatic tick();
        logic e0, e1, ev0, ev1, done;
        #2;
        e0 = 1'b0;
        e1 = 1'b0;
        if (!busy) begin
            if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
                if (last_g) e0 = 1'b1;
                else e1 = 1'b1;
`else
                e0 = 1'b1;
`endif
            end else begin
                e0 = req0_valid;
                e1 = req1_valid;
            end
        end
        ev0  = busy && (age >= 1) && !owner;
        ev1  = busy && (age >= 1) && owner;
        done = (ev0 && rsp0_ready) || (ev1 && rsp1_ready);
        check("req0_ready", 64'(req0_ready), 64'(e0));
        check("req1_ready", 64'(req1_ready), 64'(e1));
        check("rsp0_valid", 64'(rsp0_valid), 64'(ev0));
        check("rsp1_valid", 64'(rsp1_valid), 64'(ev1));
        check("ops_done", 64'(ops_done), 64'(ops_cnt));
        acc_id = -1;
        if (e0) begin
            exp0.push_back(ref_rsp(req0_op, req0_a, req0_b));
            acc_id = 0;
        end else if (e1) begin
            exp1.push_back(ref_rsp(req1_op, req1_a, req1_b));
            acc_id = 1;
        end
        @(posedge clk);
        if (done) begin
            busy    = 1'b0;
            ops_cnt = (ops_cnt + 1) % (1 << CNT_W);
        end else if (busy) begin
            age++;
        end
        if (acc_id >= 0) begin
            busy   = 1'b1;
            age    = 0;
            owner  = (acc_id == 1);
            last_g = owner;
            grants.push_back(acc_id);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_req0_ready", 64'(req0_ready), 64'd0);
        check("rst_req1_ready", 64'(req1_ready), 64'd0);
        check("rst_rsp0_valid", 64'(rsp0_valid), 64'd0);
        check("rst_rsp1_valid", 64'(rsp1_valid), 64'd0);
        check("rst_rsp_z", 64'(rsp_z), 64'd0);
        check("rst_rsp_zero", 64'(rsp_zero), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_alu_a", 64'(alu_a), 64'd0);
        check("rst_alu_b", 64'(alu_b), 64'd0);
        check("rst_alu_op", 64'(alu_op), 64'd0);
        check("rst_ops_done", 64'(ops_done), 64'd0);
        busy    = 1'b0;
        age     = 0;
        last_g  = 1'b1;
        ops_cnt = 0;
        exp0.delete();
        exp1.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (busy && k < 20) begin
            tick();
            k++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: response still pending after %0d cycles", k);
        end
    endtask

    task automatic issue(input int n, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int k;
        if (n == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        k = 0;
        acc_id = -1;
        while (acc_id != n && k < 20) begin
            tick();
            k++;
        end
        if (acc_id != n) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: requester %0d not accepted, got %0d", n, acc_id);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();
    endtask

    // Monitor: pops the scoreboard on every response handshake.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n) begin
                check("alu_op_legal", 64'(alu_op inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111}), 64'd1);
                if (rsp0_valid && rsp0_ready) begin
                    if (exp0.size() == 0) begin
                        total++; bad++;
                        $display("FAIL rsp0_unexpected: got z=%0h expected no response", rsp_z);
                    end else begin
                        e = exp0.pop_front();
                        check("rsp0_z", 64'(rsp_z), 64'(e[W+1:2]));
                        check("rsp0_zero", 64'(rsp_zero), 64'(e[1]));
                        check("rsp0_err", 64'(rsp_err), 64'(e[0]));
                        last_z = rsp_z; last_zero = rsp_zero; last_err = rsp_err;
                    end
                end
                if (rsp1_valid && rsp1_ready) begin
                    if (exp1.size() == 0) begin
                        total++; bad++;
                        $display("FAIL rsp1_unexpected: got z=%0h expected no response", rsp_z);
                    end else begin
                        e = exp1.pop_front();
                        check("rsp1_z", 64'(rsp_z), 64'(e[W+1:2]));
                        check("rsp1_zero", 64'(rsp_zero), 64'(e[1]));
                        check("rsp1_err", 64'(rsp_err), 64'(e[0]));
                        last_z = rsp_z; last_zero = rsp_zero; last_err = rsp_err;
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // Stimulus.
    initial begin
        int k;
        int exp_g [4];
        rsp_t hold;
        rst_n = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        req0_op = 3'b000; req1_op = 3'b000;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #2;
        do_reset();

        // reset while an operation is in EXEC
        req0_valid = 1'b1; req0_op = 3'b010; req0_a = 32'd1; req0_b = 32'd2;
        tick();
        req0_valid = 1'b0;
        do_reset();

        issue(0, 3'b010, 32'd5, 32'd7);
        check("add_z", 64'(last_z), 64'd12);
        check("add_zero", 64'(last_zero), 64'd0);
        issue(1, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00);
        check("and_z", 64'(last_z), 64'hF000_F000);
        issue(1, 3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00);
        check("or_z", 64'(last_z), 64'hFFF0_FFF0);
        issue(0, 3'b110, 32'd5, 32'd5);
        check("sub_z", 64'(last_z), 64'd0);
        check("sub_zero", 64'(last_zero), 64'd1);
        issue(1, 3'b111, 32'hFFFF_FFFF, 32'd1);
        check("slt_z", 64'(last_z), 64'd1);

        // contention: both valid for four grants
`ifdef ALU_ARB_RR_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        grants.delete();
        req0_valid = 1'b1; req0_op = rand_op(1'b0); req0_a = rand_val(); req0_b = rand_val();
        req1_valid = 1'b1; req1_op = rand_op(1'b0); req1_a = rand_val(); req1_b = rand_val();
        k = 0;
        while (grants.size() < 4 && k < 40) begin
            tick();
            if (acc_id == 0) begin req0_op = rand_op(1'b0); req0_a = rand_val(); req0_b = rand_val(); end
            if (acc_id == 1) begin req1_op = rand_op(1'b0); req1_a = rand_val(); req1_b = rand_val(); end
            k++;
        end
        check("contention_grants", 64'(grants.size()), 64'd4);
        for (int i = 0; i < grants.size() && i < 4; i++) begin
            check("contention_order", 64'(grants[i]), 64'(exp_g[i]));
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        // backpressure on requester 0
        req0_valid = 1'b1; req0_op = 3'b010; req0_a = rand_val(); req0_b = rand_val();
        hold = ref_rsp(req0_op, req0_a, req0_b);
        rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        k = 0; acc_id = -1;
        while (acc_id != 0 && k < 20) begin tick(); k++; end
        req0_valid = 1'b0;
        tick();
        req1_valid = 1'b1; req1_op = 3'b001; req1_a = rand_val(); req1_b = rand_val();
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp0_valid", 64'(rsp0_valid), 64'd1);
            check("bp_rsp_z", 64'(rsp_z), 64'(hold[W+1:2]));
            check("bp_req1_ready", 64'(req1_ready), 64'd0);
            check("bp_ops_done", 64'(ops_done), 64'(ops_cnt));
            tick();
        end
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        drain();
        issue(0, 3'b011, rand_val(), rand_val());
        check("illegal_err", 64'(last_err), 64'd1);
        check("illegal_z", 64'(last_z), 64'd0);

        // randomized traffic with drops, illegal ops and backpressure
        for (int i = 0; i < 300; i++) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_op = rand_op(1'b1); req0_a = rand_val(); req0_b = rand_val();
            req1_op = rand_op(1'b1); req1_a = rand_val(); req1_b = rand_val();
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        drain();

        // counter wrap with a 4-bit counter
        do_reset();
        for (int i = 0; i < 17; i++) begin
            issue(i % 2, rand_op(1'b0), rand_val(), rand_val());
        end
        check("ops_done_wrap", 64'(ops_done), 64'd1);
        check("exp0_empty", 64'(exp0.size()), 64'd0);
        check("exp1_empty", 64'(exp1.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
